lcd_ghost_filter: RTL and testbench
===================================

Name: lcd_ghost_filter

Overview:
- Per-pixel LCD persistence filter between the supervision core's 2-bit pixel stream and video_mixer.
- Keeps a frame-sized buffer of 6-bit intensity levels and moves each level toward the current pixel's target at programmable rise/fall rates.
- Maps each level to RGB by interpolating between the four active palette entries.
- Replaces the plain two-frame flickerblend average with a decaying response.

Parameters:
- H_ACTIVE, 160, active pixels per line
- V_ACTIVE, 160, active lines per frame
- ADDR_W, 15, level-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE

Ports:
- clk_sys  in  1  system clock; sole clock
- reset_n  in  1  asynchronous, active-low reset
- ce_pix  in  1  pixel enable; at most one pulse per 4 clk_sys
- pixel  in  2  core pixel, 0 = lightest
- hsync, vsync, hblank, vblank  in  1 each  core timing
- enable  in  1  0 = bypass (level forced to target)
- rise_shift  in  3  approach rate when target > level
- fall_shift  in  3  approach rate when target < level
- palette  in  96  entry0 at [95:72] .. entry3 at [23:0]; each entry is R[23:16] G[15:8] B[7:0]
- red, green, blue  out  8 each  filtered colour
- hsync_o, vsync_o, hblank_o, vblank_o  out  1 each  timing delayed to match RGB

Behaviour:
- Reset (reset_n low, asynchronous):
  - all outputs 0
  - address counter 0
  - pipeline valid bits cleared
  - init_frame flag set
- Active pixel = ce_pix & ~hblank & ~vblank.
- target = pixel*16, giving 0/16/32/48.
- Pipeline, counted in clk_sys from the ce_pix edge (C0):
  - C0: latch pixel, target and addr; issue buffer read; latch timing inputs.
  - C1: buffer data L valid (1-cycle RAM).
  - C2: compute L'; write L' to addr; register seg/frac.
  - C3: red/green/blue and the four *_o outputs update together.
- Total latency 3 clk_sys; outputs hold between updates.
- Level update, d = target - L (signed):
  - d == 0: L' = L.
  - d > 0: step = d >> rise_shift.
  - d < 0: step = |d| >> fall_shift.
  - step is forced to a minimum of 1 when d != 0, then applied toward target (L' = L ± step), so no overshoot.
  - enable == 0 or init_frame == 1: L' = target. The buffer is still written.
  - L' is always in 0..48.
- Colour mapping:
  - seg = L'[5:4], frac = L'[3:0].
  - seg == 3: output palette entry3.
  - Otherwise, per channel: c = p[seg] + floor(((p[seg+1] - p[seg]) * frac) / 16), using a signed 9x4-bit multiply and arithmetic shift right 4. Result is always in 0..255.
  - Inactive pixels: RGB = 0; no buffer read or write.
- Address counter:
  - Increments after each active pixel.
  - Wraps to 0 after H_ACTIVE*V_ACTIVE-1.
  - Cleared on any ce_pix with vsync=1; clear has priority over increment.
- init_frame clears on the first vsync 1->0 transition seen with ce_pix after at least one full frame of active pixels has been written.
- Mid-frame reset: pipeline is flushed (no write completes after reset); the next frame runs in bypass via init_frame.
- Palette or shift changes take effect on the next C0 (no resynchronisation).

Decomposition:
- Package ghost_pkg:
  - constants LEVEL_W=6, LEVEL_MAX=48, LEVEL_STEP=16
  - typedef rgb_t (struct of 3x8-bit)
  - typedef level_t
  - function palette_entry(idx)
- Sub-module ghost_lerp: combinational+registered per-channel interpolator (seg, frac, palette -> rgb_t), instantiated once.
- Buffer: existing dpram, data_width 6, addr_width ADDR_W.

Test Plan:
- Reset held 10 clk_sys with random inputs -> all outputs 0; first active pixel after release reads/writes addr 0.
- enable=0, default palette 87BA6B/6BA378/386B82/384052, pixel=3 -> RGB 0x384052 at C3; pixel=0 -> 0x87BA6B.
- enable=1, init_frame done, level 0, rise_shift=2, pixel steady 3 -> successive frames give levels 12, 21, 27.
  - Level 12 outputs RGB 0x72A874 (R 114, G 168 floor, B 116).
- Level 1, pixel 0, fall_shift=7 -> minimum step gives 0 next frame; level 48, pixel 0, fall_shift=0 -> 0 immediately.
- Address behaviour:
  - Feed 25600 active pixels without vsync -> counter wraps to 0.
  - Assert vsync mid-line -> next active pixel uses addr 0.
  - hblank pixels produce RGB 0 and no RAM write.
- Reset mid-frame with a write in C1 -> that write is suppressed; the next frame outputs exact palette colours (bypass) and initialises the buffer.

Source files
------------

// File: rtl/ghost_pkg.sv
// Shared types and helpers for the LCD ghosting filter: level encoding, colour
// and timing bundles, and palette entry extraction.
package ghost_pkg;

  localparam int unsigned LEVEL_W    = 6;
  localparam int unsigned LEVEL_MAX  = 48;
  localparam int unsigned LEVEL_STEP = 16;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblank;
    logic vblank;
  } timing_t;

  // Entry 0 sits in the top 24 bits of the packed palette.
  function automatic rgb_t palette_entry(input logic [95:0] palette, input logic [1:0] idx);
    rgb_t e;
    case (idx)
      2'd0:    e = palette[95:72];
      2'd1:    e = palette[71:48];
      2'd2:    e = palette[47:24];
      default: e = palette[23:0];
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dpram.sv
// Simple two-port RAM: one registered read port, one write port, one clock.
module dpram #(
  parameter int unsigned data_width = 8,
  parameter int unsigned addr_width = 8
) (
  input  logic                  clk_i,
  input  logic                  rd_en_i,
  input  logic [addr_width-1:0] rd_addr_i,
  output logic [data_width-1:0] rd_data_o,
  input  logic                  wr_en_i,
  input  logic [addr_width-1:0] wr_addr_i,
  input  logic [data_width-1:0] wr_data_i
);

  logic [data_width-1:0] mem_q [2**addr_width];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/ghost_lerp.sv
// Maps a 6-bit persistence level to RGB by linear interpolation between
// adjacent palette entries; result is registered.
module ghost_lerp
  import ghost_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        active_i,
  input  level_t      level_i,
  input  logic [95:0] palette_i,
  output rgb_t        rgb_o
);

  // lo + floor((hi - lo) * frac / 16), signed 9x4 multiply
  function automatic logic [7:0] lerp_ch(input logic [7:0] lo, input logic [7:0] hi,
                                         input logic [3:0] frac);
    logic signed [8:0]  diff;
    logic signed [13:0] prod;
    logic signed [9:0]  sum;
    diff = $signed({1'b0, hi}) - $signed({1'b0, lo});
    prod = 14'(diff) * 14'($signed({1'b0, frac}));
    sum  = $signed({2'b00, lo}) + 10'(prod >>> 4);
    return sum[7:0];
  endfunction

  logic [1:0] seg;
  logic [3:0] frac;
  rgb_t       lo, hi, rgb_d, rgb_q;

  always_comb begin
    seg   = level_i[5:4];
    frac  = level_i[3:0];
    lo    = palette_entry(palette_i, seg);
    hi    = palette_entry(palette_i, seg + 2'd1);
    rgb_d = '0;
    if (active_i) begin
      if (seg == 2'd3) begin
        rgb_d = lo;
      end else begin
        rgb_d.r = lerp_ch(lo.r, hi.r, frac);
        rgb_d.g = lerp_ch(lo.g, hi.g, frac);
        rgb_d.b = lerp_ch(lo.b, hi.b, frac);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rgb_q <= '0;
    end else if (en_i) begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/lcd_ghost_filter.sv
// Per-pixel LCD persistence filter: each pixel's stored level creeps toward its
// target at programmable rise/fall rates and is rendered through the palette.
module lcd_ghost_filter
  import ghost_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 160,
  parameter int unsigned V_ACTIVE = 160,
  parameter int unsigned ADDR_W   = 15
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_pix,
  input  logic [1:0]  pixel,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        hblank,
  input  logic        vblank,
  input  logic        enable,
  input  logic [2:0]  rise_shift,
  input  logic [2:0]  fall_shift,
  input  logic [95:0] palette,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        hblank_o,
  output logic        vblank_o
);

  localparam int unsigned       FrameSize = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] AddrLast  = ADDR_W'(FrameSize - 1);
  localparam level_t            LevelMax  = level_t'(LEVEL_MAX);

  typedef struct packed {
    logic              active;
    logic              bypass;
    level_t            target;
    logic [ADDR_W-1:0] addr;
    timing_t           tim;
  } stage_t;

  logic              active;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              init_frame_d, init_frame_q;
  logic              full_d, full_q;
  logic              vs_prev_d, vs_prev_q;

  stage_t  s0_d, s0_q, s1_q;
  logic    s0_valid_q, s1_valid_q, s2_valid_q;
  logic    s2_active_q;
  level_t  s2_level_q;
  timing_t s2_tim_q, tim_out_q;

  level_t ram_rd, l_cur, mag, step, level_new;
  logic   up, dn;
  rgb_t   rgb;

  assign active = ce_pix & ~hblank & ~vblank;

  // Front end: address counter and the bypass-until-first-full-frame flag.
  always_comb begin
    addr_d       = addr_q;
    init_frame_d = init_frame_q;
    full_d       = full_q;
    vs_prev_d    = vs_prev_q;
    if (ce_pix) begin
      vs_prev_d = vsync;
      if (vs_prev_q && !vsync && full_q) begin
        init_frame_d = 1'b0;
      end
      if (active && addr_q == AddrLast) begin
        full_d = 1'b1;
      end
      if (vsync) begin
        addr_d = '0;
      end else if (active) begin
        addr_d = (addr_q == AddrLast) ? '0 : addr_q + 1'b1;
      end
    end
  end

  always_comb begin
    s0_d.active = active;
    s0_d.bypass = ~enable | init_frame_q;
    s0_d.target = {pixel, 4'b0000};
    s0_d.addr   = addr_q;
    s0_d.tim    = {hsync, vsync, hblank, vblank};
  end

  // Level update; the stored level is clamped so a corrupt entry cannot escape 0..48.
  always_comb begin
    l_cur = (ram_rd > LevelMax) ? LevelMax : ram_rd;
    up    = s1_q.target > l_cur;
    dn    = s1_q.target < l_cur;
    mag   = up ? s1_q.target - l_cur : l_cur - s1_q.target;
    step  = mag >> (up ? rise_shift : fall_shift);
    if (step == '0) begin
      step = level_t'(1);
    end
    if (s1_q.bypass) begin
      level_new = s1_q.target;
    end else if (up) begin
      level_new = l_cur + step;
    end else if (dn) begin
      level_new = l_cur - step;
    end else begin
      level_new = l_cur;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= '0;
      init_frame_q <= 1'b1;
      full_q       <= 1'b0;
      vs_prev_q    <= 1'b0;
      s0_valid_q   <= 1'b0;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s0_q         <= '0;
      s1_q         <= '0;
      s2_active_q  <= 1'b0;
      s2_level_q   <= '0;
      s2_tim_q     <= '0;
      tim_out_q    <= '0;
    end else begin
      addr_q       <= addr_d;
      init_frame_q <= init_frame_d;
      full_q       <= full_d;
      vs_prev_q    <= vs_prev_d;
      s0_valid_q   <= ce_pix;
      if (ce_pix) begin
        s0_q <= s0_d;
      end
      s1_valid_q <= s0_valid_q;
      s1_q       <= s0_q;
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_active_q <= s1_q.active;
        s2_level_q  <= level_new;
        s2_tim_q    <= s1_q.tim;
      end
      if (s2_valid_q) begin
        tim_out_q <= s2_tim_q;
      end
    end
  end

  logic              rd_en, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  assign rd_en   = s0_valid_q & s0_q.active;
  assign rd_addr = s0_q.addr;
  assign wr_en   = s1_valid_q & s1_q.active;
  assign wr_addr = s1_q.addr;

  dpram #(
    .data_width(LEVEL_W),
    .addr_width(ADDR_W)
  ) u_level_buf (
    .clk_i    (clk_sys),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(ram_rd),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(level_new)
  );

  ghost_lerp u_lerp (
    .clk_i    (clk_sys),
    .rst_ni   (reset_n),
    .en_i     (s2_valid_q),
    .active_i (s2_active_q),
    .level_i  (s2_level_q),
    .palette_i(palette),
    .rgb_o    (rgb)
  );

  assign red   = rgb.r;
  assign green = rgb.g;
  assign blue  = rgb.b;
  assign {hsync_o, vsync_o, hblank_o, vblank_o} = tim_out_q;

endmodule

// File: tb/tb_lcd_ghost_filter.sv
// Directed bench for lcd_ghost_filter on a small 8x3 frame: per-frame vector
// table plus hand sequences for latency, address wrap, vsync clear and reset.
module tb_lcd_ghost_filter;

  localparam int H = 8;
  localparam int V = 3;
  localparam logic [95:0] DefPal = 96'h87BA6B_6BA378_386B82_384052;

  logic        clk;
  logic        reset_n;
  logic        ce_pix;
  logic [1:0]  pixel;
  logic        hsync, vsync, hblank, vblank;
  logic        enable;
  logic [2:0]  rise_shift, fall_shift;
  logic [95:0] palette;
  logic [7:0]  red, green, blue;
  logic        hsync_o, vsync_o, hblank_o, vblank_o;

  int n_cmp;
  int n_fail;

  lcd_ghost_filter #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .ADDR_W  (5)
  ) dut (
    .clk_sys   (clk),
    .reset_n   (reset_n),
    .ce_pix    (ce_pix),
    .pixel     (pixel),
    .hsync     (hsync),
    .vsync     (vsync),
    .hblank    (hblank),
    .vblank    (vblank),
    .enable    (enable),
    .rise_shift(rise_shift),
    .fall_shift(fall_shift),
    .palette   (palette),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .hsync_o   (hsync_o),
    .vsync_o   (vsync_o),
    .hblank_o  (hblank_o),
    .vblank_o  (vblank_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  pix;
    logic        en;
    logic [2:0]  rise;
    logic [2:0]  fall;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [23:0] exp_rgb,
                           input logic [3:0] exp_tim);
    check({name, " rgb"}, {8'h00, red, green, blue}, {8'h00, exp_rgb});
    check({name, " tim"}, 32'({hsync_o, vsync_o, hblank_o, vblank_o}), 32'(exp_tim));
  endtask

  // One pixel: C0 at the next posedge, outputs sampled on the negedge after C3.
  task automatic send(input logic [1:0] pix, input logic hs, input logic vs, input logic hb,
                      input logic vb, input logic [23:0] exp_rgb, input string name);
    @(negedge clk);
    pixel  = pix;
    hsync  = hs;
    vsync  = vs;
    hblank = hb;
    vblank = vb;
    ce_pix = 1'b1;
    @(negedge clk);
    ce_pix = 1'b0;
    repeat (3) @(negedge clk);
    check_out(name, exp_rgb, {hs, vs, hb, vb});
  endtask

  task automatic run_frame(input int idx);
    vec_t v;
    v          = tbl[idx];
    enable     = v.en;
    rise_shift = v.rise;
    fall_shift = v.fall;
    send(2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0, $sformatf("f%0d vsync", idx));
    send(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0, $sformatf("f%0d vblank", idx));
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        send(v.pix, 1'b0, 1'b0, 1'b0, 1'b0, v.exp_rgb, $sformatf("f%0d px%0d", idx, r * H + c));
      end
      // hblank pixel carries a different shade so a stray write would corrupt the next level
      send((v.pix == 2'd3) ? 2'd0 : 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0,
           $sformatf("f%0d hblank%0d", idx, r));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    tbl[0]  = '{2'd0, 1'b1, 3'd2, 3'd0, 24'h87BA6B};
    tbl[1]  = '{2'd3, 1'b1, 3'd2, 3'd0, 24'h72A874};
    tbl[2]  = '{2'd3, 1'b1, 3'd2, 3'd0, 24'h5B917B};
    tbl[3]  = '{2'd3, 1'b1, 3'd2, 3'd0, 24'h477C7E};
    tbl[4]  = '{2'd0, 1'b1, 3'd2, 3'd0, 24'h87BA6B};
    tbl[5]  = '{2'd3, 1'b0, 3'd2, 3'd0, 24'h384052};
    tbl[6]  = '{2'd0, 1'b0, 3'd2, 3'd0, 24'h87BA6B};
    tbl[7]  = '{2'd1, 1'b1, 3'd4, 3'd0, 24'h85B86B};
    tbl[8]  = '{2'd0, 1'b1, 3'd4, 3'd7, 24'h87BA6B};
    tbl[9]  = '{2'd3, 1'b1, 3'd0, 3'd0, 24'h384052};
    tbl[10] = '{2'd1, 1'b1, 3'd0, 3'd1, 24'h386B82};
    tbl[11] = '{2'd1, 1'b1, 3'd0, 3'd1, 24'h51877D};
    tbl[12] = '{2'd2, 1'b1, 3'd3, 3'd1, 24'h4E837D};
    tbl[13] = '{2'd1, 1'b1, 3'd7, 3'd7, 24'h6BA378};
    tbl[14] = '{2'd1, 1'b1, 3'd7, 3'd7, 24'h6BA378};
    tbl[15] = '{2'd2, 1'b1, 3'd2, 3'd0, 24'h5E957A};

    // Reset held with random inputs.
    reset_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ce_pix     = 1'($urandom);
      pixel      = 2'($urandom);
      hsync      = 1'($urandom);
      vsync      = 1'($urandom);
      hblank     = 1'($urandom);
      vblank     = 1'($urandom);
      enable     = 1'($urandom);
      rise_shift = 3'($urandom);
      fall_shift = 3'($urandom);
      palette    = {$urandom, $urandom, $urandom};
    end
    check_out("in reset", 24'h0, 4'h0);
    @(negedge clk);
    ce_pix     = 1'b0;
    pixel      = 2'd0;
    {hsync, vsync, hblank, vblank} = 4'h0;
    enable     = 1'b1;
    rise_shift = 3'd2;
    fall_shift = 3'd0;
    palette    = DefPal;
    reset_n    = 1'b1;
    repeat (3) @(negedge clk);
    check_out("after release", 24'h0, 4'h0);

    for (int i = 0; i <= 12; i++) begin
      run_frame(i);
    end

    // Address wrap: addr0 -> 48, rest -> 0, then one more pixel without vsync.
    enable     = 1'b1;
    rise_shift = 3'd0;
    fall_shift = 3'd0;
    send(2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0, "wrap vsync");
    send(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0, "wrap vblank");
    send(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 24'h384052, "wrap a0");
    for (int i = 1; i < H * V; i++) begin
      send(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h87BA6B, $sformatf("wrap a%0d", i));
    end
    rise_shift = 3'd7;
    @(negedge clk);
    pixel  = 2'd3;
    {hsync, vsync, hblank, vblank} = 4'h0;
    ce_pix = 1'b1;
    @(negedge clk);
    ce_pix = 1'b0;
    repeat (2) @(negedge clk);
    check_out("latency hold", 24'h87BA6B, 4'h0);
    @(negedge clk);
    check_out("wrap to addr0", 24'h384052, 4'h0);

    // vsync mid-line on an active pixel (addr1), then next active must use addr0.
    send(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h87BA6B, "midline vsync");
    send(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 24'h384052, "after vsync addr0");

    // Reset while a pixel sits between read and write.
    @(negedge clk);
    pixel  = 2'd1;
    {hsync, vsync, hblank, vblank} = 4'h0;
    ce_pix = 1'b1;
    @(negedge clk);
    ce_pix = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_out("async reset", 24'h0, 4'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check_out("flushed", 24'h0, 4'h0);

    for (int i = 13; i <= 15; i++) begin
      run_frame(i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
